// File: rtl/squeeze_serializer.sv
// SHAKE256 squeeze-side serializer: streams 1088-bit rate blocks out as 2-bit
// chunks, MSB-first, and requests further permutations until the digest length is met.
module squeeze_serializer #(
  parameter int RANGE = 1088,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             squeeze_start,
  input  logic [LEN_W-1:0] out_len_bytes,
  input  logic [RANGE-1:0] block_in,
  input  logic             block_valid,
  output logic             block_req,
  input  logic             ready,
  output logic [1:0]       serial_out,
  output logic             serial_valid,
  output logic             serial_end_signal,
  output logic             squeeze_done,
  output logic [2:0]       debug_squeeze_state,
  output logic [LEN_W-1:0] debug_squeeze_bytecount
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_BLOCK = 3'd1,
    SHIFT      = 3'd2,
    NEXT_REQ   = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam logic [7:0] LAST_BLK_BYTE = 8'(RANGE / 8 - 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bytes_sent_q, bytes_sent_d;
  logic [7:0]       blk_byte_q, blk_byte_d;
  logic [1:0]       chunk_q, chunk_d;
  logic [RANGE-1:0] shreg_q, shreg_d;
  logic             done_q, done_d;

  logic [LEN_W:0]   sent_next;
  logic             last_byte;

  // One extra bit keeps the "next byte is the last one" compare free of wrap.
  assign sent_next = {1'b0, bytes_sent_q} + 1'b1;
  assign last_byte = (sent_next == {1'b0, len_q});

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    bytes_sent_d = bytes_sent_q;
    blk_byte_d   = blk_byte_q;
    chunk_d      = chunk_q;
    shreg_d      = shreg_q;
    done_d       = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (squeeze_start) begin
          len_d        = out_len_bytes;
          bytes_sent_d = '0;
          done_d       = 1'b0;
          state_d      = (out_len_bytes != '0) ? WAIT_BLOCK : DONE;
        end else if (state_q == DONE) begin
          done_d = 1'b1;
        end
      end
      WAIT_BLOCK: begin
        if (block_valid) begin
          shreg_d    = block_in;
          blk_byte_d = '0;
          chunk_d    = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (ready) begin
          shreg_d = {shreg_q[RANGE-3:0], 2'b00};
          chunk_d = chunk_q + 2'd1;
          // End of digest takes priority over end of block.
          if (chunk_q == 2'd3) begin
            bytes_sent_d = sent_next[LEN_W-1:0];
            blk_byte_d   = blk_byte_q + 8'd1;
            if (last_byte) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else if (blk_byte_q == LAST_BLK_BYTE) begin
              state_d = NEXT_REQ;
            end
          end
        end
      end
      NEXT_REQ: begin
        state_d = WAIT_BLOCK;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      bytes_sent_q <= '0;
      blk_byte_q   <= '0;
      chunk_q      <= '0;
      shreg_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      bytes_sent_q <= bytes_sent_d;
      blk_byte_q   <= blk_byte_d;
      chunk_q      <= chunk_d;
      shreg_q      <= shreg_d;
      done_q       <= done_d;
    end
  end

  assign serial_valid            = (state_q == SHIFT);
  assign serial_out              = serial_valid ? shreg_q[RANGE-1 -: 2] : 2'b00;
  assign serial_end_signal       = serial_valid && (chunk_q == 2'd3) && last_byte;
  assign block_req               = (state_q == NEXT_REQ);
  assign squeeze_done            = done_q;
  assign debug_squeeze_state     = state_q;
  assign debug_squeeze_bytecount = bytes_sent_q;

endmodule

// File: tb/tb_squeeze_serializer.sv
// Randomized bench for squeeze_serializer: compares the chunk stream, block
// requests and completion against a byte-level model of the digest.
module tb_squeeze_serializer;

  localparam int RANGE = 1088;
  localparam int LEN_W = 11;
  localparam int BPB   = RANGE / 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             squeeze_start = 1'b0;
  logic [LEN_W-1:0] out_len_bytes = '0;
  logic [RANGE-1:0] block_in = '0;
  logic             block_valid = 1'b0;
  logic             ready = 1'b0;
  logic             block_req;
  logic [1:0]       serial_out;
  logic             serial_valid;
  logic             serial_end_signal;
  logic             squeeze_done;
  logic [2:0]       debug_squeeze_state;
  logic [LEN_W-1:0] debug_squeeze_bytecount;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] blockBytes [0:3][0:BPB-1];

  always #5 clk = ~clk;

  squeeze_serializer #(.RANGE(RANGE), .LEN_W(LEN_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .squeeze_start           (squeeze_start),
    .out_len_bytes           (out_len_bytes),
    .block_in                (block_in),
    .block_valid             (block_valid),
    .block_req               (block_req),
    .ready                   (ready),
    .serial_out              (serial_out),
    .serial_valid            (serial_valid),
    .serial_end_signal       (serial_end_signal),
    .squeeze_done            (squeeze_done),
    .debug_squeeze_state     (debug_squeeze_state),
    .debug_squeeze_bytecount (debug_squeeze_bytecount)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic fillBlocks();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < BPB; k++)
        blockBytes[b][k] = 8'($urandom_range(0, 255));
  endtask

  function automatic logic [RANGE-1:0] packBlock(input int b);
    logic [RANGE-1:0] v;
    v = '0;
    for (int k = 0; k < BPB; k++) v[RANGE-1-8*k -: 8] = blockBytes[b][k];
    return v;
  endfunction

  // Digest is the byte sequence of the blocks in order; each byte yields four 2-bit chunks, high pair first.
  function automatic int expectedChunk(input int idx);
    int byteIdx;
    logic [7:0] byteVal;
    byteIdx = idx / 4;
    byteVal = blockBytes[byteIdx / BPB][byteIdx % BPB];
    return int'((byteVal >> (6 - 2 * (idx % 4))) & 8'h03);
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, int'(serial_valid), 0);
    checkOutput({tag, "_out"}, int'(serial_out), 0);
    checkOutput({tag, "_req"}, int'(block_req), 0);
    checkOutput({tag, "_end"}, int'(serial_end_signal), 0);
    checkOutput({tag, "_done"}, int'(squeeze_done), 0);
    checkOutput({tag, "_state"}, int'(debug_squeeze_state), 0);
    checkOutput({tag, "_count"}, int'(debug_squeeze_bytecount), 0);
  endtask

  // mode 0: ready always high; 1: random ready and stray starts; 2: 3-cycle stall on every odd chunk.
  task automatic applyStimulus(input int len, input int mode, input int abortAt);
    int total;
    int idx;
    int blkIdx;
    int reqSeen;
    int cycles;
    int stall;
    int delay;
    int budget;
    bit awaiting;
    total    = len * 4;
    idx      = 0;
    blkIdx   = 0;
    reqSeen  = 0;
    cycles   = 0;
    stall    = 0;
    budget   = total * 6 + 200;
    awaiting = 1'b1;
    delay    = $urandom_range(0, 3);

    @(negedge clk);
    out_len_bytes = LEN_W'(len);
    squeeze_start = 1'b1;
    @(negedge clk);
    squeeze_start = 1'b0;

    if (len == 0) begin
      checkOutput("zero_state", int'(debug_squeeze_state), 4);
      checkOutput("zero_valid", int'(serial_valid), 0);
      checkOutput("zero_done_early", int'(squeeze_done), 0);
      @(negedge clk);
      checkOutput("zero_done", int'(squeeze_done), 1);
      checkOutput("zero_valid2", int'(serial_valid), 0);
      return;
    end

    while (idx < total && cycles < budget) begin
      if (abortAt >= 0 && idx == abortAt) begin
        #2 reset_n = 1'b0;
        #1 checkAllZero("midreset");
        @(negedge clk);
        block_valid   = 1'b0;
        ready         = 1'b0;
        squeeze_start = 1'b0;
        reset_n       = 1'b1;
        return;
      end

      if (block_req && !awaiting) begin
        reqSeen++;
        checkOutput("req_boundary", idx % (BPB * 4), 0);
        checkOutput("req_valid", int'(serial_valid), 0);
        awaiting = 1'b1;
        delay    = $urandom_range(0, 3);
      end else if (awaiting) begin
        checkOutput("req_pulse", int'(block_req), 0);
        if (serial_valid) begin
          checkOutput("valid_before_block", int'(block_valid), 1);
          block_valid = 1'b0;
          awaiting    = 1'b0;
          blkIdx++;
        end else if (!block_valid) begin
          if (delay == 0) begin
            block_in    = packBlock(blkIdx);
            block_valid = 1'b1;
          end else begin
            delay--;
          end
        end
      end else if (!serial_valid) begin
        checkOutput("valid_drop", int'(serial_valid), 1);
      end

      if (serial_valid && !awaiting) begin
        if (mode == 1) ready = 1'($urandom_range(0, 1));
        else if (mode == 2 && (idx % 2) == 1 && stall < 3) begin
          ready = 1'b0;
          stall++;
        end else ready = 1'b1;
        checkOutput("chunk", int'(serial_out), expectedChunk(idx));
        checkOutput("end_flag", int'(serial_end_signal), int'(idx == total - 1));
        checkOutput("bytecount", int'(debug_squeeze_bytecount), idx / 4);
        if (ready) begin
          idx++;
          stall = 0;
        end
      end else begin
        ready = 1'($urandom_range(0, 1));
      end

      if (mode == 1 && $urandom_range(0, 15) == 0) begin
        squeeze_start = 1'b1;
        out_len_bytes = LEN_W'($urandom_range(0, 2047));
      end else begin
        squeeze_start = 1'b0;
      end

      @(negedge clk);
      cycles++;
    end
    squeeze_start = 1'b0;
    ready         = 1'b0;

    checkOutput("chunks_sent", idx, total);
    checkOutput("final_state", int'(debug_squeeze_state), 4);
    checkOutput("final_valid", int'(serial_valid), 0);
    checkOutput("final_end", int'(serial_end_signal), 0);
    checkOutput("final_done", int'(squeeze_done), 1);
    checkOutput("final_count", int'(debug_squeeze_bytecount), len);
    checkOutput("req_total", reqSeen, (len - 1) / BPB);
    @(negedge clk);
    checkOutput("done_sticky", int'(squeeze_done), 1);
    checkOutput("done_no_req", int'(block_req), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;

    fillBlocks();
    blockBytes[0][0] = 8'hA5;
    applyStimulus(32, 0, -1);

    fillBlocks();
    applyStimulus(4, 2, -1);

    fillBlocks();
    applyStimulus(137, 0, -1);

    fillBlocks();
    applyStimulus(136, 0, -1);

    applyStimulus(0, 0, -1);

    fillBlocks();
    applyStimulus(20, 0, 40);
    checkAllZero("after_reset");

    fillBlocks();
    applyStimulus(1, 0, -1);

    for (int r = 0; r < 4; r++) begin
      fillBlocks();
      applyStimulus($urandom_range(1, 400), 1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
